// File: rtl/crono_pkg.sv
`default_nettype none
// ============================================================================
// Module  : crono_pkg
// Purpose : Shared state encoding, BCD limits and digit helpers for the
//           N-field countdown chronometer.
// Rev     : 1.0  initial release
// ============================================================================
package crono_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] SEC_TENS_MAX = 4'd5;
    localparam logic [3:0] UNITS_MAX    = 4'd9;

    // Out-of-range digits also wrap to 0 so a bad value cannot stick.
    function automatic logic [3:0] bcd_inc(input logic [3:0] digit, input logic [3:0] max);
        return (digit >= max) ? 4'd0 : digit + 4'd1;
    endfunction

    function automatic logic [3:0] bcd_dec(input logic [3:0] digit, input logic [3:0] max);
        return (digit == 4'd0) ? max : digit - 4'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_field_dec.sv
`default_nettype none
// ============================================================================
// Module  : bcd_field_dec
// Purpose : One 2-digit BCD field decrement with borrow in/out and a zero flag
//           on the decremented value.
// Rev     : 1.0  initial release
// ============================================================================
module bcd_field_dec (
    input  logic [7:0] i_value,
    input  logic [3:0] i_tens_max,
    input  logic [3:0] i_units_max,
    input  logic       i_borrow,
    output logic [7:0] o_value,
    output logic       o_borrow,
    output logic       o_zero
);

    always_comb begin
        o_value  = i_value;
        o_borrow = 1'b0;
        if (i_borrow) begin
            if (i_value[3:0] != 4'd0) begin
                o_value[3:0] = i_value[3:0] - 4'd1;
            end else begin
                o_value[3:0] = i_units_max;
                if (i_value[7:4] != 4'd0) begin
                    o_value[7:4] = i_value[7:4] - 4'd1;
                end else begin
                    o_value[7:4] = i_tens_max;
                    o_borrow     = 1'b1;
                end
            end
        end
    end

    assign o_zero = (o_value == 8'h00);

endmodule
`default_nettype wire

// File: rtl/crono_countdown_n.sv
`default_nettype none
// ============================================================================
// Module  : crono_countdown_n
// Purpose : N-field BCD time editor with 1 Hz countdown to zero.
//           Optional macro CRONO_BLINK_EN builds the cursor-digit blink.
// Rev     : 1.0  initial release
// ============================================================================
module crono_countdown_n #(
    parameter int NFIELDS  = 3,
    parameter int HOUR_MAX = 23,
    parameter int CW       = $clog2(2*NFIELDS)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   EN,
    input  logic                   BTup,
    input  logic                   BTdown,
    input  logic                   BTl,
    input  logic                   BTr,
    input  logic                   start,
    input  logic                   stop,
    input  logic                   tick,
    output logic [8*NFIELDS-1:0]   tval,
    output logic [CW-1:0]          contador,
    output logic                   running,
    output logic                   done,
    output logic                   blank
);
    import crono_pkg::*;

    localparam logic [3:0]    HOUR_TENS_MAX  = 4'(HOUR_MAX / 10);
    localparam logic [3:0]    HOUR_UNITS_MAX = 4'(HOUR_MAX % 10);
    localparam logic [CW-1:0] CUR_LAST       = CW'(2*NFIELDS - 1);

    state_t               r_state, w_state_nxt;
    logic [8*NFIELDS-1:0] r_tval, w_tval_nxt, w_tval_dec, w_tval_edit;
    logic [CW-1:0]        r_cur, w_cur_nxt;
    logic                 r_prev_up, r_prev_dn, r_prev_l, r_prev_r, r_prev_st;
    logic                 w_e_up, w_e_dn, w_e_l, w_e_r, w_e_st;
    logic [NFIELDS:0]     w_borrow;
    logic [NFIELDS-1:0]   w_zero;
    logic                 w_hit_zero;
    logic [3:0]           w_tens, w_units, w_tmax, w_umax;

    assign w_e_up = BTup   & ~r_prev_up;
    assign w_e_dn = BTdown & ~r_prev_dn;
    assign w_e_l  = BTl    & ~r_prev_l;
    assign w_e_r  = BTr    & ~r_prev_r;
    assign w_e_st = start  & ~r_prev_st;

    // Borrow chain runs from the LS field (highest index) up to field 0.
    assign w_borrow[NFIELDS] = 1'b1;

    generate
        for (genvar g = 0; g < NFIELDS; g++) begin : g_field
            localparam logic [3:0] TENS_LIM = (g == 0) ? HOUR_TENS_MAX : SEC_TENS_MAX;
            bcd_field_dec u_field (
                .i_value     (r_tval[8*(NFIELDS-g)-1 -: 8]),
                .i_tens_max  (TENS_LIM),
                .i_units_max (UNITS_MAX),
                .i_borrow    (w_borrow[g+1]),
                .o_value     (w_tval_dec[8*(NFIELDS-g)-1 -: 8]),
                .o_borrow    (w_borrow[g]),
                .o_zero      (w_zero[g])
            );
        end
    endgenerate

    // A borrow out of field 0 means we were already at zero; treat as expiry.
    assign w_hit_zero = (&w_zero) | w_borrow[0];

    always_comb begin
        w_tval_edit = r_tval;
        w_tens      = 4'd0;
        w_units     = 4'd0;
        w_tmax      = 4'd0;
        w_umax      = 4'd0;
        for (int f = 0; f < NFIELDS; f++) begin
            w_tens  = r_tval[8*(NFIELDS-f)-1 -: 4];
            w_units = r_tval[8*(NFIELDS-f)-5 -: 4];
            w_tmax  = (f == 0) ? HOUR_TENS_MAX : SEC_TENS_MAX;
            w_umax  = (f == 0 && w_tens == HOUR_TENS_MAX) ? HOUR_UNITS_MAX : UNITS_MAX;
            if (r_cur == CW'(2*f)) begin
                w_tens = w_e_up ? bcd_inc(w_tens, w_tmax) : bcd_dec(w_tens, w_tmax);
                if (f == 0 && w_tens == HOUR_TENS_MAX && w_units > HOUR_UNITS_MAX)
                    w_units = HOUR_UNITS_MAX;
            end else if (r_cur == CW'(2*f + 1)) begin
                w_units = w_e_up ? bcd_inc(w_units, w_umax) : bcd_dec(w_units, w_umax);
            end
            w_tval_edit[8*(NFIELDS-f)-1 -: 8] = {w_tens, w_units};
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_tval_nxt  = r_tval;
        w_cur_nxt   = r_cur;
        if (!EN) begin
            w_state_nxt = IDLE;
            w_cur_nxt   = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_e_r && !w_e_l)
                        w_cur_nxt = (r_cur == CUR_LAST) ? '0 : r_cur + CW'(1);
                    else if (w_e_l && !w_e_r)
                        w_cur_nxt = (r_cur == '0) ? CUR_LAST : r_cur - CW'(1);
                    if (w_e_up ^ w_e_dn)
                        w_tval_nxt = w_tval_edit;
                    if (w_e_st && (|r_tval))
                        w_state_nxt = RUN;
                end
                RUN: begin
                    if (stop) begin
                        w_state_nxt = IDLE;
                    end else if (tick && !w_e_st) begin
                        if (w_hit_zero) begin
                            w_tval_nxt  = '0;
                            w_state_nxt = DONE;
                        end else begin
                            w_tval_nxt  = w_tval_dec;
                        end
                    end
                end
                DONE: begin
                    if (stop)
                        w_state_nxt = IDLE;
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_tval    <= '0;
            r_cur     <= '0;
            r_prev_up <= 1'b0;
            r_prev_dn <= 1'b0;
            r_prev_l  <= 1'b0;
            r_prev_r  <= 1'b0;
            r_prev_st <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_tval    <= w_tval_nxt;
            r_cur     <= w_cur_nxt;
            r_prev_up <= BTup;
            r_prev_dn <= BTdown;
            r_prev_l  <= BTl;
            r_prev_r  <= BTr;
            r_prev_st <= start;
        end
    end

`ifdef CRONO_BLINK_EN
    logic r_blank;
    always_ff @(posedge clk) begin
        if (reset)
            r_blank <= 1'b0;
        else if (!EN || r_state != IDLE || w_state_nxt != IDLE ||
                 w_e_up || w_e_dn || w_e_l || w_e_r)
            r_blank <= 1'b0;
        else if (tick)
            r_blank <= ~r_blank;
    end
    assign blank = r_blank;
`else
    assign blank = 1'b0;
`endif

    assign tval     = r_tval;
    assign contador = r_cur;
    assign running  = (r_state == RUN);
    assign done     = (r_state == DONE);

endmodule
`default_nettype wire
